// File: rtl/ram_ctrl.sv
// Two-port arbiter and pin sequencer for the shared single-port tristate RAM.
// Writes use setup/strobe/hold around ram_d; reads end with a bus turnaround cycle.
module ram_ctrl #(
  parameter int N = 68,
  parameter int M = 8,
  parameter int A = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         we0,
  input  logic         we1,
  input  logic [A-1:0] addr0,
  input  logic [A-1:0] addr1,
  input  logic [M-1:0] wdata0,
  input  logic [M-1:0] wdata1,
  output logic         ack0,
  output logic         ack1,
  output logic         err0,
  output logic         err1,
  output logic [M-1:0] rdata0,
  output logic [M-1:0] rdata1,
  output logic         ram_act,
  output logic         ram_we,
  output logic         ram_d,
  output logic [A-1:0] ram_addr,
  inout  wire  [M-1:0] ram_data
);

  typedef enum logic [3:0] {
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_SETUP,
    RD_WAIT,
    RD_CAPTURE,
    TURN,
    ERR
  } state_t;

  state_t       state;
  state_t       next_state;
  logic         ptr;
  logic         gnt;
  logic [M-1:0] lat_wdata;
  logic         drive;
  logic         sel;
  logic         sel_we;
  logic [A-1:0] sel_addr;
  logic [M-1:0] sel_wdata;
  logic         grant;
  logic         bad_addr;
  logic         done;

  // Both requesting: the pointer decides; otherwise whichever port is asking.
  always_comb begin
    sel       = (req0 && req1) ? ptr : req1;
    sel_we    = sel ? we1 : we0;
    sel_addr  = sel ? addr1 : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    grant     = (state == IDLE) && (req0 || req1);
    bad_addr  = sel_addr > A'(N);
  end

  assign done     = (state == WR_HOLD) || (state == RD_CAPTURE) || (state == ERR);
  assign ram_data = drive ? lat_wdata : {M{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // RAM pins decode from state only; RD_WAIT gives the RAM an access cycle.
  always_comb begin
    next_state = state;
    ram_act    = 1'b0;
    ram_we     = 1'b0;
    ram_d      = 1'b0;
    drive      = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          if (bad_addr)    next_state = ERR;
          else if (sel_we) next_state = WR_SETUP;
          else             next_state = RD_SETUP;
        end
      end
      WR_SETUP: begin
        ram_act    = 1'b1;
        ram_we     = 1'b1;
        drive      = 1'b1;
        next_state = WR_STROBE;
      end
      WR_STROBE: begin
        ram_act    = 1'b1;
        ram_we     = 1'b1;
        ram_d      = 1'b1;
        drive      = 1'b1;
        next_state = WR_HOLD;
      end
      WR_HOLD: begin
        ram_act    = 1'b1;
        ram_we     = 1'b1;
        drive      = 1'b1;
        next_state = IDLE;
      end
      RD_SETUP: begin
        ram_act    = 1'b1;
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        ram_act    = 1'b1;
        next_state = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        ram_act    = 1'b1;
        next_state = TURN;
      end
      TURN:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Out-of-range requests never touch ram_addr, so it keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      lat_wdata <= '0;
      ram_addr  <= '0;
    end else if (grant) begin
      gnt       <= sel;
      lat_wdata <= sel_wdata;
      if (!bad_addr)      ram_addr <= sel_addr;
      if (req0 && req1)   ptr      <= ~sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      ack0 <= done && !gnt;
      ack1 <= done && gnt;
      err0 <= (state == ERR) && !gnt;
      err1 <= (state == ERR) && gnt;
      if (state == RD_CAPTURE && !gnt) rdata0 <= ram_data;
      if (state == RD_CAPTURE && gnt)  rdata1 <= ram_data;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: a behavioural RAM on the shared bus, a bus keeper that
// exposes any stray controller drive, and a per-port ack scoreboard.
module tb_ram_ctrl;
  localparam int N = 68;
  localparam int M = 8;
  localparam int A = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, we0, we1;
  logic [A-1:0] addr0, addr1;
  logic [M-1:0] wdata0, wdata1;
  logic         ack0, ack1, err0, err1;
  logic [M-1:0] rdata0, rdata1;
  logic         ram_act, ram_we, ram_d;
  logic [A-1:0] ram_addr;
  wire  [M-1:0] ram_data;

  logic [7:0] mem [0:127];

  typedef struct {
    logic       is_read;
    logic       err;
    logic [7:0] rdata;
    int         ack_cyc;
  } exp_t;

  typedef struct {
    logic       port;
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  vec_t vecs[13];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int next_free = 0;
  int bus_viol = 0;
  int strobe_cnt = 0;
  int act_cnt = 0;
  int watch_cnt = 0;

  ram_ctrl #(.N(N), .M(M), .A(A)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_act(ram_act), .ram_we(ram_we), .ram_d(ram_d),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM drives only in read cycles; the keeper holds 0 whenever the RAM is idle.
  assign ram_data = (ram_act && !ram_we) ? mem[ram_addr] : 8'hzz;
  assign ram_data = ram_act ? 8'hzz : 8'h00;
  always @(negedge clk) if (ram_act && ram_we && ram_d) mem[ram_addr] <= ram_data;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic is_read, input logic err,
                          input logic [7:0] rdata, input int ack_cyc);
    exp_t e;
    e.is_read = is_read;
    e.err     = err;
    e.rdata   = rdata;
    e.ack_cyc = ack_cyc;
    if (port) exp_q1.push_back(e);
    else      exp_q0.push_back(e);
  endtask

  task automatic score(input logic port, input logic ack, input logic err, input logic [7:0] rdata);
    exp_t e;
    if (ack) begin
      if ((port ? exp_q1.size() : exp_q0.size()) == 0) begin
        check_output(port ? "unexpected_ack1" : "unexpected_ack0", ack, 0);
      end else begin
        if (port) e = exp_q1.pop_front();
        else      e = exp_q0.pop_front();
        check_output(port ? "ack1_cycle" : "ack0_cycle", cyc, e.ack_cyc);
        check_output(port ? "err1" : "err0", err, e.err);
        if (e.is_read) check_output(port ? "rdata1" : "rdata0", rdata, e.rdata);
      end
    end else if (err) begin
      check_output(port ? "err1_without_ack" : "err0_without_ack", err, 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (ram_act && !ram_we && ram_data !== mem[ram_addr]) bus_viol++;
      if (!ram_act && (ram_data !== 8'h00 || ram_we || ram_d)) bus_viol++;
      if (ram_d) strobe_cnt++;
      if (ram_act) act_cnt++;
      if (ram_we && ram_act && ram_addr == 7'd5 && ram_data === 8'hA5) watch_cnt++;
      score(1'b0, ack0, err0, rdata0);
      score(1'b1, ack1, err1, rdata1);
    end
  endtask

  // Called at a falling edge; grant edge is the next edge the idle controller can accept.
  task automatic apply_stimulus(input logic port, input logic we, input logic [6:0] addr,
                                input logic [7:0] wdata, input logic exp_err,
                                input logic [7:0] exp_rdata, input bit track);
    int g;
    g = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    next_free = g + (exp_err ? 2 : (we ? 4 : 5));
    if (track) push_exp(port, !we && !exp_err, exp_err, exp_rdata, g + (exp_err ? 1 : 3));
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic wait_ack(input logic port);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (port ? ack1 : ack0) seen = 1;
    end
    check_output(port ? "ack1_timeout" : "ack0_timeout", seen, 1);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  initial begin
    int s0, s1, g, n0, n1;
    bit seen;

    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    vecs[0]  = '{1'b0, 1'b0, 7'd5,   8'h00, 1'b0, 8'hA5};
    vecs[1]  = '{1'b1, 1'b1, 7'd68,  8'h3C, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 7'd0,   8'hC3, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 7'd68,  8'h00, 1'b0, 8'h3C};
    vecs[4]  = '{1'b0, 1'b0, 7'd0,   8'h00, 1'b0, 8'hC3};
    vecs[5]  = '{1'b0, 1'b1, 7'd127, 8'hFF, 1'b1, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 7'd20,  8'h5A, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 7'd21,  8'h81, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 7'd22,  8'h7E, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b1, 7'd23,  8'hE7, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 7'd20,  8'h00, 1'b0, 8'h5A};
    vecs[11] = '{1'b0, 1'b1, 7'd10,  8'h11, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 1'b0, 7'd10,  8'h00, 1'b0, 8'h11};

    repeat (2) @(negedge clk);
    check_output("rst_ram_act", ram_act, 0);
    check_output("rst_ram_we", ram_we, 0);
    check_output("rst_ram_d", ram_d, 0);
    check_output("rst_ram_addr", ram_addr, 0);
    check_output("rst_acks_errs", {ack0, ack1, err0, err1}, 0);
    check_output("rst_rdata", {rdata0, rdata1}, 0);
    check_output("rst_bus_released", ram_data, 8'h00);
    rst_n = 1'b1;
    next_free = 0;

    // Write 0xA5 to 5: one strobe cycle, address/data stable for three cycles.
    s0 = strobe_cnt;
    s1 = watch_cnt;
    apply_stimulus(1'b0, 1'b1, 7'd5, 8'hA5, 1'b0, 8'h00, 1'b1);
    wait_ack(1'b0);
    check_output("strobe_cycles", strobe_cnt - s0, 1);
    check_output("wr_stable_cycles", watch_cnt - s1, 3);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                     vecs[i].exp_err, vecs[i].exp_rdata, 1'b1);
      wait_ack(vecs[i].port);
    end

    // Out-of-range read on port 1 must never activate the RAM.
    s0 = act_cnt;
    apply_stimulus(1'b1, 1'b0, 7'd69, 8'h00, 1'b1, 8'h00, 1'b1);
    wait_ack(1'b1);
    check_output("err_ram_act_cycles", act_cnt - s0, 0);

    // Read then write of the same location from the two ports.
    apply_stimulus(1'b0, 1'b0, 7'd10, 8'h00, 1'b0, 8'h11, 1'b1);
    wait_ack(1'b0);
    check_output("turn_ram_act", ram_act, 0);
    apply_stimulus(1'b1, 1'b1, 7'd10, 8'h99, 1'b0, 8'h00, 1'b1);
    wait_ack(1'b1);
    apply_stimulus(1'b0, 1'b0, 7'd10, 8'h00, 1'b0, 8'h99, 1'b1);
    wait_ack(1'b0);

    // Both ports reading from reset: grants alternate 0,1,0,1 five cycles apart.
    rst_n = 1'b0;
    tick();
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'd20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'd21;
    rst_n = 1'b1;
    g = cyc + 1;
    push_exp(1'b0, 1'b1, 1'b0, 8'h5A, g + 3);
    push_exp(1'b1, 1'b1, 1'b0, 8'h81, g + 8);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 40 && (n0 < 2 || n1 < 2); i++) begin
      tick();
      if (ack0) begin
        n0++;
        if (n0 == 1) begin
          addr0 = 7'd22;
          push_exp(1'b0, 1'b1, 1'b0, 8'h7E, g + 13);
        end else req0 = 1'b0;
      end
      if (ack1) begin
        n1++;
        if (n1 == 1) begin
          addr1 = 7'd23;
          push_exp(1'b1, 1'b1, 1'b0, 8'hE7, g + 18);
        end else req1 = 1'b0;
      end
    end
    check_output("both_reads_done", n0 + n1, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    next_free = g + 20;

    // Reset while the strobe is high: outputs clear at once and no ack follows.
    apply_stimulus(1'b0, 1'b1, 7'd30, 8'h42, 1'b0, 8'h00, 1'b0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (ram_d) seen = 1;
    end
    check_output("strobe_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_ram_act", ram_act, 0);
    check_output("async_ram_we", ram_we, 0);
    check_output("async_ram_d", ram_d, 0);
    check_output("async_ram_addr", ram_addr, 0);
    check_output("async_rdata0", rdata0, 0);
    check_output("async_bus_released", ram_data, 8'h00);
    req0 = 1'b0;
    tick();
    check_output("reset_no_ack", {ack0, ack1}, 0);
    rst_n = 1'b1;
    next_free = 0;
    repeat (4) tick();
    apply_stimulus(1'b0, 1'b1, 7'd30, 8'h42, 1'b0, 8'h00, 1'b1);
    wait_ack(1'b0);
    apply_stimulus(1'b0, 1'b0, 7'd30, 8'h00, 1'b0, 8'h42, 1'b1);
    wait_ack(1'b0);
    repeat (3) tick();

    check_output("bus_ownership_violations", bus_viol, 0);
    check_output("scoreboard_leftover", exp_q0.size() + exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
